// File: rtl/truth_table_checker.sv
// ============================================================================
// Module   : truth_table_checker
// Purpose  : Exhaustive stimulus/response checker for a single-output
//            combinational DUT, in binary or Gray-code sweep order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [(1<<N)-1:0]  expect_tt,
  input  logic               dut_y,
  output logic [N-1:0]       vec,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N:0]         err_count,
  output logic               fail_valid,
  output logic [N-1:0]       first_fail_vec
);

  localparam logic [N-1:0] SEQ_LAST = {N{1'b1}};
  localparam logic [3:0]   SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        seq_q, seq_d;
  logic [3:0]          settle_q, settle_d;
  logic                mode_q, mode_d;
  logic [(1<<N)-1:0]   tt_q, tt_d;
  logic [N:0]          err_q, err_d;
  logic                fv_q, fv_d;
  logic [N-1:0]        first_q, first_d;
  logic                pass_q, pass_d;

  logic [N-1:0]        vec_cur;
  logic                mismatch;

  // seq stays put after the last vector, so vec keeps showing it while idle.
  assign vec_cur  = mode_q ? (seq_q ^ (seq_q >> 1)) : seq_q;
  assign mismatch = (dut_y != tt_q[vec_cur]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seq_q    <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
      tt_q     <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      first_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      tt_q     <= tt_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    tt_d     = tt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    first_d  = first_q;
    pass_d   = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_APPLY;
          mode_d   = mode;
          tt_d     = expect_tt;
          err_d    = '0;
          fv_d     = 1'b0;
          first_d  = '0;
          pass_d   = 1'b0;
          seq_d    = '0;
          settle_d = '0;
        end
      end
      S_APPLY: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_C) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d    = 1'b1;
            first_d = vec_cur;
          end
        end
        if (seq_q == SEQ_LAST) begin
          state_d = S_DONE;
          // Verdict must include the sample being taken on this edge.
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          seq_d    = seq_q + 1'b1;
          settle_d = '0;
          state_d  = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign vec            = vec_cur;
  assign busy           = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = first_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module   : tb_truth_table_checker
// Purpose  : Directed table-driven bench; two checkers (SETTLE=1 and 0)
//            each beside a behavioural DUT with injectable output faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

  typedef struct {
    int          sel;
    logic        md;
    logic [15:0] tt;
    logic [15:0] flip;
    int          poke;
    logic [4:0]  err;
    logic        fv;
    logic [3:0]  first;
    logic        pass;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start;
  logic        mode;
  logic [15:0] tt;
  logic [15:0] flip;
  logic        y0, y1;
  logic [3:0]  vec_w   [2];
  logic [4:0]  err_w   [2];
  logic [3:0]  first_w [2];
  logic [1:0]  busy_w, done_w, pass_w, fv_w;

  int total = 0;
  int bad   = 0;

  logic [3:0] gray_tab [16];
  rec_t       recs [8];

  always #5 clk = ~clk;

  // Behavioural DUTs: the reference function with selected outputs inverted.
  assign y0 = tt[vec_w[0]] ^ flip[vec_w[0]];
  assign y1 = tt[vec_w[1]] ^ flip[vec_w[1]];

  truth_table_checker #(.N(4), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode), .expect_tt(tt),
    .dut_y(y0), .vec(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .fail_valid(fv_w[0]),
    .first_fail_vec(first_w[0])
  );

  truth_table_checker #(.N(4), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode), .expect_tt(tt),
    .dut_y(y1), .vec(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .fail_valid(fv_w[1]),
    .first_fail_vec(first_w[1])
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input int s, input logic [3:0] v, input logic b,
                             input logic d, input logic p, input logic [4:0] e,
                             input logic f, input logic [3:0] ff, input string tag);
    chk({tag, ".vec"},   16'(vec_w[s]),   16'(v));
    chk({tag, ".busy"},  16'(busy_w[s]),  16'(b));
    chk({tag, ".done"},  16'(done_w[s]),  16'(d));
    chk({tag, ".pass"},  16'(pass_w[s]),  16'(p));
    chk({tag, ".err"},   16'(err_w[s]),   16'(e));
    chk({tag, ".fv"},    16'(fv_w[s]),    16'(f));
    chk({tag, ".first"}, 16'(first_w[s]), 16'(ff));
  endtask

  task automatic run_rec(input rec_t r, input string tag);
    int         cpv;
    logic [3:0] ev;
    cpv = (r.sel == 1) ? 2 : 3;
    @(negedge clk);
    mode = r.md; tt = r.tt; flip = r.flip; start[r.sel] = 1'b1;
    @(posedge clk); #1;
    start[r.sel] = 1'b0;
    for (int c = 0; c < 16 * cpv; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start[r.sel] = 1'b0;
      end
      ev = r.md ? gray_tab[c / cpv] : 4'(c / cpv);
      chk({tag, ".run_busy"}, 16'(busy_w[r.sel]), 16'd1);
      chk({tag, ".run_vec"},  16'(vec_w[r.sel]),  16'(ev));
      chk({tag, ".run_done"}, 16'(done_w[r.sel]), 16'd0);
      if (c == r.poke * cpv) start[r.sel] = 1'b1;
    end
    @(posedge clk); #1;
    chk_outputs(r.sel, r.md ? 4'd8 : 4'd15, 1'b0, 1'b1, r.pass, r.err, r.fv,
                r.first, {tag, ".done"});
    @(posedge clk); #1;
    chk_outputs(r.sel, r.md ? 4'd8 : 4'd15, 1'b0, 1'b0, r.pass, r.err, r.fv,
                r.first, {tag, ".after"});
  endtask

  initial begin
    logic seen_done;
    gray_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    //            sel md  tt         flip       poke err    fv    first  pass
    recs[0] = '{0, 1'b0, 16'hA5C3, 16'h0000, -1, 5'd0,  1'b0, 4'h0, 1'b1};
    recs[1] = '{0, 1'b0, 16'hA5C3, 16'h0840, -1, 5'd2,  1'b1, 4'h6, 1'b0};
    recs[2] = '{1, 1'b1, 16'hA5C3, 16'h0000, -1, 5'd0,  1'b0, 4'h0, 1'b1};
    recs[3] = '{0, 1'b0, 16'hA5C3, 16'hFFFF, -1, 5'd16, 1'b1, 4'h0, 1'b0};
    recs[4] = '{0, 1'b0, 16'hA5C3, 16'h0000,  7, 5'd0,  1'b0, 4'h0, 1'b1};
    recs[5] = '{1, 1'b1, 16'h3C96, 16'h0090, -1, 5'd2,  1'b1, 4'h7, 1'b0};
    recs[6] = '{1, 1'b0, 16'hFFFF, 16'h8000, -1, 5'd1,  1'b1, 4'hF, 1'b0};
    recs[7] = '{0, 1'b1, 16'h0000, 16'h0001, -1, 5'd1,  1'b1, 4'h0, 1'b0};

    rst = 1'b1; start = 2'b00; mode = 1'b0; tt = 16'h0; flip = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs(0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, "reset_s1");
    chk_outputs(1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, "reset_s0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_rec(recs[i], $sformatf("rec%0d", i));
    end

    // Asynchronous reset in the middle of a run with one recorded error.
    @(negedge clk);
    mode = 1'b0; tt = 16'hA5C3; flip = 16'h0001; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst.pre_vec", 16'(vec_w[0]), 16'd5);
    chk("midrst.pre_err", 16'(err_w[0]), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk_outputs(0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, "midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done_w[0] || busy_w[0]) seen_done = 1'b1;
    end
    chk("midrst.no_done", 16'(seen_done), 16'd0);
    run_rec(recs[0], "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
